obq_branch_tracker: RTL and testbench

Control-side companion of the outstanding branch queue: it drives the queue's write, clear and shift ports. It allocates a queue tag to each dispatched branch and builds that branch's history row. It tracks out-of-order resolution, and issues a clear on a mispredict and a shift when the oldest branch commits. It sits between dispatch, the branch execution unit, and the ROB on one side and the queue on the other.

---
 rtl/obq_branch_tracker_pkg.sv | 25 ++
 rtl/obq_window_check.sv | 22 ++
 rtl/obq_branch_tracker.sv | 163 ++++++++++++++++
 tb/tb_obq_branch_tracker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obq_branch_tracker_pkg.sv
// Shared types and sizing for the outstanding-branch-queue tracker.
// The queue row layout lives here so the tracker and the queue agree on it.
package obq_branch_tracker_pkg;

  localparam int OBQ_DEPTH   = 8;
  localparam int OBQ_BH_BITS = 8;

  typedef struct packed {
    logic [OBQ_BH_BITS-1:0] branch_history;
  } obq_row_t;

  typedef enum logic [0:0] {
    BT_NORMAL  = 1'b0,
    BT_RECOVER = 1'b1
  } bt_state_t;

  // Shift the predicted direction in as the MSB; the queue inverts that bit on a clear.
  function automatic logic [OBQ_BH_BITS-1:0] push_history(
    input logic                   taken,
    input logic [OBQ_BH_BITS-1:0] bh
  );
    return {taken, bh[OBQ_BH_BITS-1:1]};
  endfunction

endpackage

// File: rtl/obq_window_check.sv
// Tests whether a tag lies in the live window [head, tail) with pointer wrap,
// and reports its age offset from head.
module obq_window_check #(
  parameter int TAG_W = 3
) (
  input  logic [TAG_W-1:0] tag,
  input  logic [TAG_W:0]   head,
  input  logic [TAG_W:0]   tail,
  output logic             in_window,
  output logic [TAG_W-1:0] offset
);

  logic [TAG_W:0] live_s;

  // Offset wraps modulo the queue size; the pointer MSB keeps full distinct from empty.
  always_comb begin
    offset    = tag - head[TAG_W-1:0];
    live_s    = tail - head;
    in_window = ({1'b0, offset} < live_s);
  end

endmodule

// File: rtl/obq_branch_tracker.sv
// Allocates queue tags to dispatched branches, tracks out-of-order resolution,
// and drives the branch queue's write, clear and shift ports.
module obq_branch_tracker
  import obq_branch_tracker_pkg::*;
#(
  parameter int OBQ_SIZE = OBQ_DEPTH,
  parameter int BH_SIZE  = OBQ_BH_BITS,
  parameter int TAG_W    = $clog2(OBQ_SIZE)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dispatch_valid,
  input  logic               dispatch_taken,
  input  logic [BH_SIZE-1:0] dispatch_bh,
  output logic               dispatch_ready,
  output logic [TAG_W-1:0]   dispatch_tag,
  input  logic               resolve_valid,
  input  logic [TAG_W-1:0]   resolve_tag,
  input  logic               resolve_mispredict,
  input  logic               commit_valid,
  output logic               commit_ready,
  output logic               obq_write_en,
  output obq_row_t           obq_bh_row,
  output logic               obq_clear_en,
  output logic [TAG_W-1:0]   obq_clear_index,
  output logic               obq_shift_en,
  output logic [TAG_W-1:0]   obq_shift_index,
  output logic               recovering,
  output logic [TAG_W:0]     count
);

  localparam logic [TAG_W:0] CAPACITY = (TAG_W+1)'(OBQ_SIZE - 1);

  logic [OBQ_SIZE-1:0] valid_q, valid_d, resolved_q, resolved_d;
  logic [TAG_W:0]      head_q, head_d, tail_q, tail_d;
  bt_state_t           state_q, state_d;

  logic             obq_write_en_q, obq_write_en_d;
  obq_row_t         obq_bh_row_q, obq_bh_row_d;
  logic             obq_clear_en_q, obq_clear_en_d;
  logic [TAG_W-1:0] obq_clear_index_q, obq_clear_index_d;
  logic             obq_shift_en_q, obq_shift_en_d;
  logic [TAG_W-1:0] obq_shift_index_q, obq_shift_index_d;

  logic             in_window_s;
  logic [TAG_W-1:0] res_off_s;
  logic [TAG_W-1:0] head_tag_s, tail_tag_s;
  logic             resolve_acc_s, mispredict_acc_s, dispatch_fire_s, commit_fire_s;

  obq_window_check #(.TAG_W(TAG_W)) u_resolve_window (
    .tag       (resolve_tag),
    .head      (head_q),
    .tail      (tail_q),
    .in_window (in_window_s),
    .offset    (res_off_s)
  );

  // Status outputs from registered state; dispatch_ready is held low while reset is asserted.
  always_comb begin
    head_tag_s     = head_q[TAG_W-1:0];
    tail_tag_s     = tail_q[TAG_W-1:0];
    count          = tail_q - head_q;
    recovering     = (state_q == BT_RECOVER);
    dispatch_tag   = tail_tag_s;
    dispatch_ready = reset & (count < CAPACITY) & (state_q == BT_NORMAL);
    commit_ready   = valid_q[head_tag_s] & resolved_q[head_tag_s];
  end

  // Event acceptance, entry/pointer update and the next values of the queue-facing outputs.
  always_comb begin
    logic [TAG_W-1:0] slot_off;
    resolve_acc_s    = resolve_valid & in_window_s;
    mispredict_acc_s = resolve_acc_s & resolve_mispredict;
    dispatch_fire_s  = dispatch_valid & dispatch_ready & ~mispredict_acc_s;
    commit_fire_s    = commit_valid & commit_ready;

    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    slot_off   = {TAG_W{1'b0}};

    if (resolve_acc_s) begin
      resolved_d[resolve_tag] = 1'b1;
    end else begin
      resolved_d = resolved_q;
    end

    if (mispredict_acc_s) begin
      for (int i = 0; i < OBQ_SIZE; i++) begin
        slot_off = TAG_W'(i) - head_tag_s;
        if (slot_off > res_off_s) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end else begin
          valid_d[i] = valid_d[i];
        end
      end
      tail_d = head_q + {1'b0, res_off_s} + {{TAG_W{1'b0}}, 1'b1};
    end else if (dispatch_fire_s) begin
      valid_d[tail_tag_s]    = 1'b1;
      resolved_d[tail_tag_s] = 1'b0;
      tail_d                 = tail_q + {{TAG_W{1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end

    if (commit_fire_s) begin
      valid_d[head_tag_s]    = 1'b0;
      resolved_d[head_tag_s] = 1'b0;
      head_d                 = head_q + {{TAG_W{1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end

    state_d           = mispredict_acc_s ? BT_RECOVER : BT_NORMAL;
    obq_write_en_d    = dispatch_fire_s;
    obq_bh_row_d      = dispatch_fire_s ? obq_row_t'(push_history(dispatch_taken, dispatch_bh))
                                        : obq_row_t'({OBQ_BH_BITS{1'b0}});
    obq_clear_en_d    = mispredict_acc_s;
    obq_clear_index_d = mispredict_acc_s ? (resolve_tag + {{(TAG_W-1){1'b0}}, 1'b1})
                                         : {TAG_W{1'b0}};
    obq_shift_en_d    = commit_fire_s;
    obq_shift_index_d = commit_fire_s ? head_tag_s : {TAG_W{1'b0}};
  end

  // State and registered queue controls; reset drops any clear still pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q           <= {OBQ_SIZE{1'b0}};
      resolved_q        <= {OBQ_SIZE{1'b0}};
      head_q            <= {(TAG_W+1){1'b0}};
      tail_q            <= {(TAG_W+1){1'b0}};
      state_q           <= BT_NORMAL;
      obq_write_en_q    <= 1'b0;
      obq_bh_row_q      <= obq_row_t'({OBQ_BH_BITS{1'b0}});
      obq_clear_en_q    <= 1'b0;
      obq_clear_index_q <= {TAG_W{1'b0}};
      obq_shift_en_q    <= 1'b0;
      obq_shift_index_q <= {TAG_W{1'b0}};
    end else begin
      valid_q           <= valid_d;
      resolved_q        <= resolved_d;
      head_q            <= head_d;
      tail_q            <= tail_d;
      state_q           <= state_d;
      obq_write_en_q    <= obq_write_en_d;
      obq_bh_row_q      <= obq_bh_row_d;
      obq_clear_en_q    <= obq_clear_en_d;
      obq_clear_index_q <= obq_clear_index_d;
      obq_shift_en_q    <= obq_shift_en_d;
      obq_shift_index_q <= obq_shift_index_d;
    end
  end

  assign obq_write_en    = obq_write_en_q;
  assign obq_bh_row      = obq_bh_row_q;
  assign obq_clear_en    = obq_clear_en_q;
  assign obq_clear_index = obq_clear_index_q;
  assign obq_shift_en    = obq_shift_en_q;
  assign obq_shift_index = obq_shift_index_q;

endmodule

// File: tb/tb_obq_branch_tracker.sv
// Scoreboard bench for obq_branch_tracker: expected queue-port activity is queued
// as each cycle's stimulus is set up and compared after the clock edge.
module tb_obq_branch_tracker;
  import obq_branch_tracker_pkg::*;

  logic       clock, reset;
  logic       dispatch_valid, dispatch_taken;
  logic [7:0] dispatch_bh;
  logic       dispatch_ready;
  logic [2:0] dispatch_tag;
  logic       resolve_valid, resolve_mispredict;
  logic [2:0] resolve_tag;
  logic       commit_valid, commit_ready;
  logic       obq_write_en;
  obq_row_t   obq_bh_row;
  logic       obq_clear_en;
  logic [2:0] obq_clear_index;
  logic       obq_shift_en;
  logic [2:0] obq_shift_index;
  logic       recovering;
  logic [3:0] count;

  typedef struct packed {
    logic       we;
    logic [7:0] row;
    logic       ce;
    logic [2:0] ci;
    logic       se;
    logic [2:0] si;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  obq_branch_tracker dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_taken(dispatch_taken),
    .dispatch_bh(dispatch_bh), .dispatch_ready(dispatch_ready),
    .dispatch_tag(dispatch_tag), .resolve_valid(resolve_valid),
    .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .obq_write_en(obq_write_en), .obq_bh_row(obq_bh_row),
    .obq_clear_en(obq_clear_en), .obq_clear_index(obq_clear_index),
    .obq_shift_en(obq_shift_en), .obq_shift_index(obq_shift_index),
    .recovering(recovering), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic dt, input logic [7:0] dbh,
                       input logic rv, input logic [2:0] rt, input logic rm,
                       input logic cv);
    dispatch_valid = dv; dispatch_taken = dt; dispatch_bh = dbh;
    resolve_valid = rv; resolve_tag = rt; resolve_mispredict = rm;
    commit_valid = cv;
  endtask

  task automatic expect_obq(input logic we, input logic [7:0] row, input logic ce,
                            input logic [2:0] ci, input logic se, input logic [2:0] si);
    exp_t e;
    e.we = we; e.row = row; e.ce = ce; e.ci = ci; e.se = se; e.si = si;
    exp_q.push_back(e);
  endtask

  // Clock one cycle, then compare the queue ports against the oldest expectation.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_we"},  32'(obq_write_en),    32'(e.we));
      chk({tag, "_row"}, 32'(obq_bh_row),      32'(e.row));
      chk({tag, "_ce"},  32'(obq_clear_en),    32'(e.ce));
      chk({tag, "_ci"},  32'(obq_clear_index), 32'(e.ci));
      chk({tag, "_se"},  32'(obq_shift_en),    32'(e.se));
      chk({tag, "_si"},  32'(obq_shift_index), 32'(e.si));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(dispatch_ready), 32'd0);
    chk({tag, "_dtag"},  32'(dispatch_tag),   32'd0);
    chk({tag, "_cready"}, 32'(commit_ready),  32'd0);
    chk({tag, "_we"},    32'(obq_write_en),   32'd0);
    chk({tag, "_row"},   32'(obq_bh_row),     32'd0);
    chk({tag, "_ce"},    32'(obq_clear_en),   32'd0);
    chk({tag, "_ci"},    32'(obq_clear_index), 32'd0);
    chk({tag, "_se"},    32'(obq_shift_en),   32'd0);
    chk({tag, "_si"},    32'(obq_shift_index), 32'd0);
    chk({tag, "_rec"},   32'(recovering),     32'd0);
    chk({tag, "_cnt"},   32'(count),          32'd0);
  endtask

  // Assert reset away from the active edge, hold it across one edge, then release.
  task automatic do_reset(input string tag);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk_all_zero({tag, "_now"});
    @(posedge clock);
    #2;
    chk_all_zero({tag, "_held"});
    reset = 1'b1;
    #1;
    chk({tag, "_ready_after"}, 32'(dispatch_ready), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    #3;
    chk_all_zero("por");
    @(negedge clock);
    do_reset("rst0");

    // Three taken dispatches with empty history.
    for (int i = 0; i < 3; i++) begin
      chk("t1_tag", 32'(dispatch_tag), 32'(i));
      drive(1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
      expect_obq(1'b1, 8'h80, 1'b0, 3'd0, 1'b0, 3'd0);
      step("t1_disp");
    end
    chk("t1_count", 32'(count), 32'd3);

    // Fill to capacity; the eighth dispatch is refused.
    for (int i = 3; i < 7; i++) begin
      chk("t2_ready", 32'(dispatch_ready), 32'd1);
      drive(1'b1, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
      expect_obq(1'b1, 8'h7F, 1'b0, 3'd0, 1'b0, 3'd0);
      step("t2_disp");
    end
    chk("t2_count", 32'(count), 32'd7);
    chk("t2_full_ready", 32'(dispatch_ready), 32'd0);
    drive(1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step("t2_refused");
    chk("t2_count_hold", 32'(count), 32'd7);
    chk("t2_tag_hold", 32'(dispatch_tag), 32'd7);

    // Mispredict on tag 2 of five.
    do_reset("rst1");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'h3C, 1'b0, 3'd0, 1'b0, 1'b0);
      expect_obq(1'b1, 8'h9E, 1'b0, 3'd0, 1'b0, 3'd0);
      step("t3_disp");
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b0);
    expect_obq(1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0);
    step("t3_mis");
    chk("t3_rec", 32'(recovering), 32'd1);
    chk("t3_tag", 32'(dispatch_tag), 32'd3);
    chk("t3_count", 32'(count), 32'd3);
    chk("t3_ready_rec", 32'(dispatch_ready), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 1'b1, 1'b0);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step("t3_outwin");
    chk("t3_rec_done", 32'(recovering), 32'd0);
    chk("t3_ready_back", 32'(dispatch_ready), 32'd1);
    chk("t3_count2", 32'(count), 32'd3);

    // Commit path: resolve then commit; unresolved commits are ignored.
    drive(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step("t4_res0");
    chk("t4_cready", 32'(commit_ready), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd0);
    step("t4_com0");
    chk("t4_count", 32'(count), 32'd2);
    chk("t4_cready1", 32'(commit_ready), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step("t4_com_unres");
    chk("t4_count_hold", 32'(count), 32'd2);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b1);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step("t4_res_com_same");
    chk("t4_cready_now", 32'(commit_ready), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd1);
    step("t4_com1");
    chk("t4_cready2", 32'(commit_ready), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd2);
    step("t4_com2");
    chk("t4_empty", 32'(count), 32'd0);

    // Mispredict, dispatch and commit in one cycle.
    do_reset("rst2");
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
      expect_obq(1'b1, 8'h80, 1'b0, 3'd0, 1'b0, 3'd0);
      step("t5_disp");
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step("t5_res0");
    drive(1'b1, 1'b1, 8'h55, 1'b1, 3'd1, 1'b1, 1'b1);
    expect_obq(1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd0);
    step("t5_triple");
    chk("t5_count", 32'(count), 32'd1);
    chk("t5_rec", 32'(recovering), 32'd1);
    chk("t5_tag", 32'(dispatch_tag), 32'd2);

    // Cycle twelve branches through so tags wrap, then mispredict the last slot.
    do_reset("rst3");
    for (int i = 0; i < 12; i++) begin
      chk("t6_tag", 32'(dispatch_tag), 32'(i % 8));
      drive(1'b1, i[0], 8'(i), 1'b0, 3'd0, 1'b0, 1'b0);
      expect_obq(1'b1, {i[0], 7'(i >> 1)}, 1'b0, 3'd0, 1'b0, 3'd0);
      step("t6_disp");
      drive(1'b0, 1'b0, 8'h00, 1'b1, 3'(i % 8), 1'b0, 1'b0);
      expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
      step("t6_res");
      drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
      expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 3'(i % 8));
      step("t6_com");
    end
    chk("t6_count", 32'(count), 32'd0);
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
      expect_obq(1'b1, 8'h80, 1'b0, 3'd0, 1'b0, 3'd0);
      step("t6_disp2");
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 1'b1, 1'b0);
    expect_obq(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 3'd0);
    step("t6_mis_wrap");
    chk("t6_rec", 32'(recovering), 32'd1);
    chk("t6_count4", 32'(count), 32'd4);
    chk("t6_tag0", 32'(dispatch_tag), 32'd0);

    // Reset while recovering: everything drops at once.
    do_reset("rst_mid_rec");
    drive(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    expect_obq(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    step("t7_idle");
    chk("t7_rec", 32'(recovering), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
